// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter_if
// Description : Bundles the icache, dcache and RAM-side signals of the
//               cache/memory arbiter. The arbiter uses the slave modport.
//               The environment driving the caches and the RAM model uses
//               the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
    parameter int DATA_W = 32
);
    // icache side
    logic              iREN;
    logic [DATA_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    // dcache side
    logic              dREN;
    logic              dWEN;
    logic [DATA_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    // RAM side
    logic              ramREN;
    logic              ramWEN;
    logic [DATA_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    // status
    logic              err;

    // Arbiter view
    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output err
    );

    // Caches-plus-RAM view
    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Serialises icache and dcache memory requests onto a single
//               RAM port. dcache has fixed priority; an icache request that
//               has been passed over STARVE_LIMIT times in a row is granted
//               next. A grant is held until RAM reports ACCESS, and every new
//               grant passes through one IDLE cycle.
//               Optional macro ARB_PERF_CNT_EN adds the 32-bit completion
//               counters icount and dcount.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          CLK,
    input  wire logic          nRST,
    cache_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]        icount,
    output logic [31:0]        dcount
`endif
);

    // RAM status encodings the arbiter reacts to; FREE and BUSY both mean
    // "keep waiting" and need no decode of their own.
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [DATA_W-1:0] ZERO_W = '0;

    // The starvation counter only has to reach STARVE_LIMIT, where it saturates.
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             err_q, err_d;

    logic w_dreq;
    logic w_access;
    logic w_error;
    logic w_force_i;

    assign w_dreq   = bus.dREN | bus.dWEN;
    assign w_access = (bus.ramstate == RAM_ACCESS);
    assign w_error  = (bus.ramstate == RAM_ERROR);

    // A waiting icache request wins over dcache once dcache has taken
    // STARVE_LIMIT grants in a row. A limit of 0 switches the rule off.
    assign w_force_i = bus.iREN && (STARVE_LIMIT != 0) && (starve_q >= LIMIT_C);

    // State, starvation counter and sticky error flag
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Next-state and fully combinational bus outputs for the current grant
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        err_d        = err_q;

        bus.iwait    = bus.iREN;
        bus.dwait    = w_dreq;
        bus.iload    = ZERO_W;
        bus.dload    = ZERO_W;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = ZERO_W;
        bus.ramstore = ZERO_W;

        case (state_q)
            IDLE: begin
                // The icache is no longer waiting, so it cannot be starving.
                if (!bus.iREN) begin
                    starve_d = '0;
                end
                if (w_dreq && !w_force_i) begin
                    state_d = D_XFER;
                end else if (bus.iREN) begin
                    state_d = I_XFER;
                end
            end

            D_XFER: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                // A write takes precedence when both strobes are raised.
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dwait    = ~w_access;
                if (w_access) begin
                    bus.dload = bus.ramload;
                end
                // ERROR is recorded, but the grant stays while RAM retries.
                if (w_error) begin
                    err_d = 1'b1;
                end
                if (!w_dreq) begin
                    // Request withdrawn: abandon without a completion.
                    state_d = IDLE;
                end else if (w_access) begin
                    state_d = IDLE;
                    if (bus.iREN && (starve_q < LIMIT_C)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end

            I_XFER: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                bus.iwait   = ~w_access;
                bus.iload   = bus.ramload;
                if (w_error) begin
                    err_d = 1'b1;
                end
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (w_access) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.err = err_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] icount_q;
    logic [31:0] dcount_q;
    logic        w_i_done;
    logic        w_d_done;

    // A completion is an ACCESS cycle while the granted request is still up.
    assign w_i_done = (state_q == I_XFER) && bus.iREN && w_access;
    assign w_d_done = (state_q == D_XFER) && w_dreq && w_access;

    // Free-running completion counters; they wrap at 2^32 on their own.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icount_q <= '0;
            dcount_q <= '0;
        end else begin
            if (w_i_done) begin
                icount_q <= icount_q + 32'd1;
            end
            if (w_d_done) begin
                dcount_q <= dcount_q + 32'd1;
            end
        end
    end

    assign icount = icount_q;
    assign dcount = dcount_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed, self-checking bench for cache_mem_arbiter. A
//               bus-ownership model predicts every output on every falling
//               edge. Directed sequences add literal expectations for the
//               reset state, first grant, priority, starvation, error and
//               reset-abort cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic CLK;
    logic nRST;

    cache_mem_arbiter_if #(.DATA_W(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] icount;
    logic [31:0] dcount;
`endif

    cache_mem_arbiter #(
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .icount (icount),
        .dcount (dcount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: who owns the RAM port (0 none, 1 icache, 2 dcache), how many
    // dcache wins in a row the icache has sat through, the error flag and
    // completion totals.
    // ------------------------------------------------------------------
    int owner = 0;
    int starve = 0;
    bit merr = 1'b0;
    int icomp = 0;
    int dcomp = 0;
    bit mvalid = 1'b0;

    initial begin : compare
        int  n_owner, n_starve, n_icomp, n_dcomp;
        bit  n_err, n_valid;
        bit  ireq, dreq, acc;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        logic        e_ren, e_wen, e_iwait, e_dwait;
        forever begin
            @(negedge CLK);
            ireq = bus.iREN;
            dreq = bus.dREN | bus.dWEN;
            acc  = (bus.ramstate == 2'd2);
            if (mvalid) begin
                e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
                e_ren = 0; e_wen = 0; e_iwait = ireq; e_dwait = dreq;
                if (owner == 2) begin
                    e_addr  = bus.daddr;
                    e_store = bus.dstore;
                    e_wen   = bus.dWEN;
                    e_ren   = bus.dREN && !bus.dWEN;
                    e_dwait = !acc;
                    e_dload = acc ? bus.ramload : 32'h0;
                end else if (owner == 1) begin
                    e_addr  = bus.iaddr;
                    e_ren   = ireq;
                    e_iwait = !acc;
                    e_iload = bus.ramload;
                end
                chk("m_ramaddr",  bus.ramaddr,  e_addr);
                chk("m_ramstore", bus.ramstore, e_store);
                chk("m_ramREN",   32'(bus.ramREN), 32'(e_ren));
                chk("m_ramWEN",   32'(bus.ramWEN), 32'(e_wen));
                chk("m_iwait",    32'(bus.iwait),  32'(e_iwait));
                chk("m_dwait",    32'(bus.dwait),  32'(e_dwait));
                chk("m_iload",    bus.iload, e_iload);
                chk("m_dload",    bus.dload, e_dload);
                chk("m_err",      32'(bus.err), 32'(merr));
`ifdef ARB_PERF_CNT_EN
                chk("m_icount",   icount, 32'(icomp));
                chk("m_dcount",   dcount, 32'(dcomp));
`endif
            end

            n_owner = owner; n_starve = starve; n_err = merr;
            n_icomp = icomp; n_dcomp = dcomp; n_valid = mvalid;
            if (!nRST) begin
                n_owner = 0; n_starve = 0; n_err = 0;
                n_icomp = 0; n_dcomp = 0; n_valid = 1'b1;
            end else if (owner == 0) begin
                if (!ireq) n_starve = 0;
                if (dreq && !(ireq && LIMIT != 0 && starve >= LIMIT)) n_owner = 2;
                else if (ireq) n_owner = 1;
            end else begin
                if (bus.ramstate == 2'd3) n_err = 1'b1;
                if (owner == 1) begin
                    if (!ireq) n_owner = 0;
                    else if (acc) begin
                        n_owner = 0; n_starve = 0; n_icomp = icomp + 1;
                    end
                end else begin
                    if (!dreq) n_owner = 0;
                    else if (acc) begin
                        n_owner = 0; n_dcomp = dcomp + 1;
                        if (ireq && starve < LIMIT) n_starve = starve + 1;
                    end
                end
            end

            @(posedge CLK);
            owner = n_owner; starve = n_starve; merr = n_err;
            icomp = n_icomp; dcomp = n_dcomp; mvalid = n_valid;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin : driver
        int  dn;
        bit  seen;
        nRST = 1'b0;
        bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = 2'd0;

        // Reset with icache requesting
        step();
        step();
        chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst_err",    32'(bus.err),    32'd0);
        chk("rst_iwait",  32'(bus.iwait),  32'd1);
        nRST = 1'b1;
        step();                                 // grant edge
        bus.ramstate = 2'd2; bus.ramload = 32'hDEAD_BEEF;
        #1;
        chk("i1_ramaddr", bus.ramaddr, 32'h0000_0040);
        chk("i1_iwait",   32'(bus.iwait), 32'd0);
        chk("i1_iload",   bus.iload, 32'hDEAD_BEEF);
        step();
        bus.iREN = 1'b0; bus.ramstate = 2'd0;
        step();

        // Simultaneous icache read and dcache write: dcache first
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h1234;
        bus.ramstate = 2'd1;
        step();
        chk("pri_ramWEN",   32'(bus.ramWEN), 32'd1);
        chk("pri_ramstore", bus.ramstore, 32'h1234);
        chk("pri_ramaddr",  bus.ramaddr, 32'h100);
        chk("pri_iwait",    32'(bus.iwait), 32'd1);
        bus.ramstate = 2'd2;
        #1;
        chk("pri_dwait",    32'(bus.dwait), 32'd0);
        step();
        bus.dWEN = 1'b0; bus.ramstate = 2'd0;
        #1;
        chk("pri_idle_ramREN", 32'(bus.ramREN), 32'd0);
        step();
        chk("pri_i_ramREN",  32'(bus.ramREN), 32'd1);
        chk("pri_i_ramaddr", bus.ramaddr, 32'h80);
        bus.ramstate = 2'd2;
        step();
        bus.iREN = 1'b0; bus.ramstate = 2'd0;
        step();

        // Starvation: dcache read held with icache waiting, RAM always ready
        bus.iREN = 1'b1; bus.iaddr = 32'h400;
        bus.dREN = 1'b1; bus.daddr = 32'h500;
        bus.ramstate = 2'd2; bus.ramload = 32'h0BAD_F00D;
        for (int r = 0; r < 2; r++) begin
            dn = 0; seen = 1'b0;
            for (int c = 0; c < 30 && !seen; c++) begin
                #1;
                if (bus.iwait == 1'b0) seen = 1'b1;
                else if (bus.dwait == 1'b0) dn++;
                step();
            end
            chk("starve_i_seen", 32'(seen), 32'd1);
            chk("starve_d_before_i", 32'(dn), 32'd4);
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = 2'd0;
        step();

        // Read+write together, then ERROR retries before ACCESS
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h55;
        bus.ramstate = 2'd1;
        step();
        chk("rw_ramWEN", 32'(bus.ramWEN), 32'd1);
        chk("rw_ramREN", 32'(bus.ramREN), 32'd0);
        bus.ramstate = 2'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("errc_dwait", 32'(bus.dwait), 32'd1);
            step();
        end
        chk("errc_err_set", 32'(bus.err), 32'd1);
        bus.ramstate = 2'd2;
        #1;
        chk("errc_dwait_acc", 32'(bus.dwait), 32'd0);
        step();
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = 2'd0;
        step();
        chk("errc_err_sticky", 32'(bus.err), 32'd1);

        // dcache withdraws mid-transfer: strobes fall, no completion
        bus.dREN = 1'b1; bus.daddr = 32'h600; bus.ramstate = 2'd1;
        step();
        chk("drop_ramREN_on", 32'(bus.ramREN), 32'd1);
        bus.dREN = 1'b0;
        #1;
        chk("drop_ramREN_off", 32'(bus.ramREN), 32'd0);
        step();

        // Reset asserted in the second cycle of an icache transfer
        bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.ramstate = 2'd1;
        step();
        step();
        nRST = 1'b0;
        #1;
        chk("rabort_iwait_before", 32'(bus.iwait), 32'd1);
        step();
        chk("rabort_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rabort_iwait",  32'(bus.iwait),  32'd1);
        chk("rabort_err",    32'(bus.err),    32'd0);
`ifdef ARB_PERF_CNT_EN
        chk("rabort_icount", icount, 32'd0);
`endif
        step();
        nRST = 1'b1; bus.iREN = 1'b0; bus.ramstate = 2'd0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
